// File: rtl/traffic_pkg.sv
// Shared types for the traffic light front end: request FSM states,
// per-channel request/response bundles and the next-state function.
package traffic_pkg;

  localparam int DEBOUNCE_CYC_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    SERVE = 2'd2
  } req_state_e;

  typedef struct packed {
    logic raw;
    logic g;
  } ch_req_t;

  typedef struct packed {
    logic x;
    logic det;
  } ch_rsp_t;

  // A falling det never cancels PEND; only a green clears the latch.
  function automatic req_state_e req_next(input req_state_e cur, input logic det,
                                          input logic g);
    req_state_e nxt;
    nxt = IDLE;
    case (cur)
      IDLE:    nxt = det ? (g ? SERVE : PEND) : IDLE;
      PEND:    nxt = g ? SERVE : PEND;
      SERVE:   nxt = g ? SERVE : (det ? PEND : IDLE);
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sensor_channel.sv
// One sensor direction: 2-flop synchronizer, stability debounce and the
// service-request latch that feeds the light controller.
module sensor_channel
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int CNT_W        = 3
) (
  input  logic    clk,
  input  logic    rst_n,
  input  ch_req_t req_i,
  output ch_rsp_t rsp_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic             det_q, det_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_state_e       state_q, state_d;
  logic             x_q;

  // The counter only advances while the synchronized level disagrees with det;
  // any agreeing cycle throws away the partial run.
  always_comb begin
    det_d = det_q;
    cnt_d = '0;
    if (sync_q[1] != det_q) begin
      if (cnt_q == CNT_MAX) det_d = sync_q[1];
      else                  cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign state_d = req_next(state_q, det_q, req_i.g);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      det_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= IDLE;
      x_q     <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], req_i.raw};
      det_q   <= det_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      x_q     <= (state_d == PEND);
    end
  end

  assign rsp_o.x   = x_q;
  assign rsp_o.det = det_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Two independent sensor channels feeding the two-way light controller.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sense0_raw,
  input  logic sense1_raw,
  input  logic g0,
  input  logic g1,
  output logic x0,
  output logic x1,
  output logic det0,
  output logic det1
);

  localparam int NUM_CH = 2;

  ch_req_t [NUM_CH-1:0] req;
  ch_rsp_t [NUM_CH-1:0] rsp;

  assign req[0] = '{raw: sense0_raw, g: g0};
  assign req[1] = '{raw: sense1_raw, g: g1};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sensor_channel #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst),
      .req_i(req[c]),
      .rsp_o(rsp[c])
    );
  end

  assign x0   = rsp[0].x;
  assign det0 = rsp[0].det;
  assign x1   = rsp[1].x;
  assign det1 = rsp[1].det;

endmodule
